// File: rtl/estop_conditioner_if.sv
// estop_conditioner_if: raw safety pins in, conditioned SoC conduit signals out.
interface estop_conditioner_if;
  logic       estop_raw_n;
  logic       power_sense_raw_n;
  logic       rearm;
  logic       emergency_off;
  logic       power_sense_n;
  logic       tripped_led;
  logic [7:0] trip_count;
  modport slave (
    input  estop_raw_n, power_sense_raw_n, rearm,
    output emergency_off, power_sense_n, tripped_led, trip_count
  );
  modport master (
    output estop_raw_n, power_sense_raw_n, rearm,
    input  emergency_off, power_sense_n, tripped_led, trip_count
  );
endinterface

// File: rtl/estop_conditioner.sv
// estop_conditioner: sync/debounce of estop, power sense and rearm with latched trip/re-arm FSM.
// ESTOP_AUTO_REARM_EN: re-arm automatically after a second release debounce instead of a rearm edge.
module estop_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic                clk,
  input logic                reset_n,
  estop_conditioner_if.slave io
);
  typedef enum logic [1:0] {RUN, TRIP, RELEASED} state_e;
`ifdef ESTOP_AUTO_REARM_EN
  localparam bit AUTO_REARM = 1'b1;
`else
  localparam bit AUTO_REARM = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_e           state_q, state_d;
  logic [1:0]       estop_sync_q, ps_sync_q, rearm_sync_q;
  logic             rearm_prev_q;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d, ps_cnt_q, ps_cnt_d;
  logic             ps_n_q, ps_n_d, eoff_q;
  logic [7:0]       trip_cnt_q, trip_cnt_d;
  logic             estop_rel, rearm_pulse, rel_counting, rel_done, ps_diff, ps_done, go_run;
  assign estop_rel   = estop_sync_q[1];
  assign rearm_pulse = rearm_sync_q[1] & ~rearm_prev_q;
`ifdef ESTOP_AUTO_REARM_EN
  assign go_run = rel_done;
`else
  assign go_run = rearm_pulse;
`endif
  always_comb begin
    rel_counting = estop_rel && (state_q == TRIP || (AUTO_REARM && state_q == RELEASED));
    rel_done     = rel_counting && rel_cnt_q == LAST;
    rel_cnt_d    = (rel_counting && !rel_done) ? rel_cnt_q + 1'b1 : '0;
    ps_diff      = ps_sync_q[1] != ps_n_q;
    ps_done      = ps_diff && ps_cnt_q == LAST;
    ps_cnt_d     = (ps_diff && !ps_done) ? ps_cnt_q + 1'b1 : '0;
    ps_n_d       = ps_done ? ~ps_n_q : ps_n_q;
    state_d      = state_q;
    trip_cnt_d   = trip_cnt_q;
    // a pressed button wins over any release or re-arm event in every state
    if (!estop_rel) begin
      state_d    = TRIP;
      trip_cnt_d = (state_q == RUN && trip_cnt_q != 8'hFF) ? trip_cnt_q + 8'd1 : trip_cnt_q;
    end else if (state_q == TRIP && rel_done)
      state_d = RELEASED;
    else if (state_q == RELEASED && go_run)
      state_d = RUN;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estop_sync_q <= 2'b00;
      ps_sync_q    <= 2'b11;
      rearm_sync_q <= 2'b00;
      rearm_prev_q <= 1'b0;
      state_q      <= TRIP;
      rel_cnt_q    <= '0;
      ps_cnt_q     <= '0;
      ps_n_q       <= 1'b1;
      eoff_q       <= 1'b1;
      trip_cnt_q   <= 8'd0;
    end else begin
      estop_sync_q <= {estop_sync_q[0], io.estop_raw_n};
      ps_sync_q    <= {ps_sync_q[0], io.power_sense_raw_n};
      rearm_sync_q <= {rearm_sync_q[0], io.rearm};
      rearm_prev_q <= rearm_sync_q[1];
      state_q      <= state_d;
      rel_cnt_q    <= rel_cnt_d;
      ps_cnt_q     <= ps_cnt_d;
      ps_n_q       <= ps_n_d;
      eoff_q       <= state_d != RUN;
      trip_cnt_q   <= trip_cnt_d;
    end
  end
  assign io.emergency_off = eoff_q;
  assign io.tripped_led   = eoff_q;
  assign io.power_sense_n = ps_n_q;
  assign io.trip_count    = trip_cnt_q;
endmodule

// File: tb/tb_estop_conditioner.sv
// tb_estop_conditioner: directed checks of trip latency, release debounce, rearm, power-sense debounce and reset.
module tb_estop_conditioner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_tc = 0;
  estop_conditioner_if io();
  estop_conditioner #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (.clk(clk), .reset_n(reset_n), .io(io));
  always #5 clk = ~clk;
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    io.estop_raw_n = 1'b1;
    io.power_sense_raw_n = 1'b1;
    io.rearm = 1'b0;
    ticks(3);
    check("rst_eoff", 8'(io.emergency_off), 8'd1);
    check("rst_led", 8'(io.tripped_led), 8'd1);
    check("rst_psn", 8'(io.power_sense_n), 8'd1);
    check("rst_tc", io.trip_count, 8'd0);
    reset_n = 1'b1;
    // rearm pulse lands on edge 18, the same edge RELEASED is entered: discarded
    ticks(15);
    io.rearm = 1'b1;
    ticks(10);
    check("early_rearm_ignored", 8'(io.emergency_off), 8'd1);
    io.rearm = 1'b0;
    ticks(5);
    io.rearm = 1'b1;
    ticks(2);
    check("rearm_lat2", 8'(io.emergency_off), 8'd1);
    ticks(1);
    check("rearm_lat3", 8'(io.emergency_off), 8'd0);
    check("run_led", 8'(io.tripped_led), 8'd0);
    check("run_tc", io.trip_count, 8'd0);
    io.rearm = 1'b0;
    ticks(3);
    io.estop_raw_n = 1'b0;
    ticks(1);
    io.estop_raw_n = 1'b1;
    ticks(1);
    check("trip_lat2", 8'(io.emergency_off), 8'd0);
    ticks(1);
    check("trip_lat3", 8'(io.emergency_off), 8'd1);
    check("trip_tc1", io.trip_count, 8'd1);
    for (int i = 0; i < 7; i++) begin
      ticks(5);
      io.estop_raw_n = ~io.estop_raw_n;
    end
    ticks(5);
    io.estop_raw_n = 1'b1;
    ticks(15);
    io.rearm = 1'b1;
    ticks(9);
    check("bounce_release_18", 8'(io.emergency_off), 8'd1);
    check("bounce_tc", io.trip_count, 8'd1);
    io.rearm = 1'b0;
    ticks(4);
    io.rearm = 1'b1;
    ticks(3);
    check("bounce_rearm", 8'(io.emergency_off), 8'd0);
    io.estop_raw_n = 1'b0;
    ticks(3);
    check("held_trip", 8'(io.emergency_off), 8'd1);
    check("held_tc2", io.trip_count, 8'd2);
    io.estop_raw_n = 1'b1;
    ticks(30);
    check("held_no_rearm", 8'(io.emergency_off), 8'd1);
    io.rearm = 1'b0;
    ticks(3);
    io.rearm = 1'b1;
    ticks(2);
    check("held_relatch_lat2", 8'(io.emergency_off), 8'd1);
    ticks(1);
    check("held_relatch_lat3", 8'(io.emergency_off), 8'd0);
    io.rearm = 1'b0;
    io.estop_raw_n = 1'b0;
    ticks(3);
    check("sim_tc3", io.trip_count, 8'd3);
    io.estop_raw_n = 1'b1;
    ticks(20);
    io.estop_raw_n = 1'b0;
    io.rearm = 1'b1;
    ticks(3);
    check("sim_trip", 8'(io.emergency_off), 8'd1);
    ticks(5);
    check("sim_stays_trip", 8'(io.emergency_off), 8'd1);
    check("sim_tc_same", io.trip_count, 8'd3);
    io.estop_raw_n = 1'b1;
    io.rearm = 1'b0;
    ticks(20);
    io.rearm = 1'b1;
    ticks(3);
    check("sim_recover", 8'(io.emergency_off), 8'd0);
    io.rearm = 1'b0;
    io.power_sense_raw_n = 1'b0;
    ticks(10);
    io.power_sense_raw_n = 1'b1;
    ticks(25);
    check("ps_short_pulse", 8'(io.power_sense_n), 8'd1);
    io.power_sense_raw_n = 1'b0;
    ticks(17);
    check("ps_fall_17", 8'(io.power_sense_n), 8'd1);
    ticks(1);
    check("ps_fall_18", 8'(io.power_sense_n), 8'd0);
    ticks(2);
    io.power_sense_raw_n = 1'b1;
    ticks(17);
    check("ps_rise_17", 8'(io.power_sense_n), 8'd0);
    ticks(1);
    check("ps_rise_18", 8'(io.power_sense_n), 8'd1);
    exp_tc = 3;
    for (int i = 0; i < 300; i++) begin
      io.estop_raw_n = 1'b0;
      ticks(3);
      exp_tc = (exp_tc < 255) ? exp_tc + 1 : 255;
      check("sat_tc", io.trip_count, 8'(exp_tc));
      io.estop_raw_n = 1'b1;
      ticks(19);
      io.rearm = 1'b1;
      ticks(3);
      io.rearm = 1'b0;
      ticks(2);
    end
    check("sat_run", 8'(io.emergency_off), 8'd0);
    io.power_sense_raw_n = 1'b0;
    ticks(20);
    check("mid_psn0", 8'(io.power_sense_n), 8'd0);
    io.estop_raw_n = 1'b0;
    ticks(3);
    check("mid_tc255", io.trip_count, 8'd255);
    io.estop_raw_n = 1'b1;
    io.power_sense_raw_n = 1'b1;
    ticks(8);
    reset_n = 1'b0;
    #2;
    check("async_tc", io.trip_count, 8'd0);
    check("async_eoff", 8'(io.emergency_off), 8'd1);
    check("async_led", 8'(io.tripped_led), 8'd1);
    check("async_psn", 8'(io.power_sense_n), 8'd1);
    ticks(2);
    reset_n = 1'b1;
    // rearm pulse lands on edge 19, one after RELEASED is entered: accepted
    ticks(16);
    io.rearm = 1'b1;
    ticks(2);
    check("post_rst_lat18", 8'(io.emergency_off), 8'd1);
    ticks(1);
    check("post_rst_lat19", 8'(io.emergency_off), 8'd0);
    io.rearm = 1'b0;
    ticks(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
